approx_mul_share_ctrl: RTL
==========================

# approx_mul_share_ctrl

Round-robin scheduler that time-shares one 8x8 unsigned multiplier between NREQ requesters. Each grant is per-operation exact or per-operation approximate. Approximate mode is the two-term low-column-truncated approximation, the same arithmetic as the unsigned_exchange l=2 multipliers. The block sits between client engines (filters, MAC sequencers) and the shared multiplier datapath. It holds a two-stage pipeline: issue register, then result register. Handshakes are valid/ready and backpressure propagates end to end.

## Interface
- NREQ, 4: number of requesters, 2..8.
- IDW, 3: width of the response tag; must satisfy 2**IDW >= NREQ.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  per-requester accept; at most one bit is high per cycle.
- req_x  in  8*NREQ  operand x, packed; requester i uses bits [8i+7:8i].
- req_y  in  8*NREQ  operand y, packed the same way.
- req_approx  in  NREQ  1 = approximate product, 0 = exact product.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accept.
- rsp_z  out  16  product.
- rsp_id  out  IDW  index of the requester that issued the operation.
- rsp_approx  out  1  echo of the mode used for this result.
- cnt_exact  out  16  count of exact results delivered; saturates at 0xFFFF.
- cnt_approx  out  16  count of approximate results delivered; saturates at 0xFFFF.

## Operation
- **Arbitration**
  - Round-robin over requesters whose req_valid is high, starting at pointer rr_ptr.
  - Search order: rr_ptr, rr_ptr+1, …, wrapping modulo NREQ.
  - A grant asserts req_ready[g] only when stage 1 can accept (see Timing).
  - A transfer on requester g occurs when req_valid[g] && req_ready[g].
  - On a transfer, rr_ptr <= (g+1) mod NREQ. With no transfer, rr_ptr holds.
- **Stage 1 (issue register)** captures x, y, approx and id = g, and sets s1_valid.
- **Stage 2 (result register)** computes the product from the stage-1 contents.
  - Exact mode: z = x*y, full 16 bits.
  - Approximate mode: z = ({y*x[7:2]} << 2) + c.
  - y*x[7:2] is a 14-bit product.
  - c is a 9-bit value with c[6:0] = 0.
  - c[7] = (y[7]&x[0]) | (y[6]&x[1]).
  - c[8] = y[7]&x[1].
  - The sum is computed in 16 bits and never overflows.
  - Stage 2 drives rsp_z, rsp_id, rsp_approx and rsp_valid.
- **Counters**
  - On each response transfer (rsp_valid && rsp_ready), the counter selected by rsp_approx increments by 1.
  - Each counter holds at 0xFFFF once reached.
- **Request-side rules**
  - Requesters must hold operands stable while valid and not yet accepted.
  - The block never reads operands on non-transfer cycles.
  - Dropping req_valid before acceptance is legal; that requester is simply not granted.

## Timing
- **Reset** (rst_n low, asynchronous):
  - s1_valid = 0, rsp_valid = 0, rsp_z = 0, rsp_id = 0, rsp_approx = 0.
  - rr_ptr = 0, cnt_exact = 0, cnt_approx = 0, req_ready = 0.
  - Reset asserted mid-operation discards all in-flight operations; no response is produced for them.
  - Deassertion is synchronized externally. The first grant is possible in the first cycle after deassertion.
- **Latency**: a transfer at edge N gives rsp_valid = 1 after edge N+1, i.e. 2 cycles from the issue cycle to the response cycle, when there is no backpressure.
- **Throughput**: one operation per cycle while rsp_ready stays high.
- **Stall rules**
  - Stage 2 loads when !rsp_valid || rsp_ready.
  - Stage 1 can accept when !s1_valid || stage-2-loads.
  - Stage 1 clears (s1_valid <= 0) when stage 2 loads and there is no new transfer.
  - req_ready is combinational from req_valid, rr_ptr and the stall state. No combinational path exists from req_x or req_y to any output.
- **Response hold**: rsp_* are stable while rsp_valid && !rsp_ready.
- **Full pipeline**: with both stages full and rsp_ready low, all req_ready are 0.
- **Simultaneous events**: a response transfer and a new grant in the same cycle are both honoured. Counters update only on the response transfer.

## Test plan
- **Exact path**: NREQ=4, only req 2 issues x=200, y=150, approx=0 -> two cycles later rsp_z=30000, rsp_id=2, rsp_approx=0; cnt_exact=1.
- **Approximate path**:
  - x=3, y=255, approx=1 -> rsp_z=384.
  - x=255, y=255, approx=1 -> rsp_z=64644.
  - x=255, y=255, approx=0 -> rsp_z=65025.
  - After all three: cnt_approx=2, cnt_exact=1.
- **Round-robin fairness**: all four requesters valid continuously with rsp_ready=1 -> grant order 0,1,2,3,0,1…; one response per cycle; rsp_id follows the same order.
- **Backpressure**: rsp_ready=0 for 5 cycles with all requesters valid -> exactly 2 operations accepted, then req_ready=0; the held rsp_* stay unchanged; on rsp_ready=1, the results drain in order with no loss or duplication.
- **Reset mid-flight**: assert rst_n=0 while both stages are full -> all outputs, counters and rr_ptr return to 0 immediately; no stale response after release.
- **Counter saturation**: force 65537 approximate transfers (or preload via a bench hook) -> cnt_approx stops at 0xFFFF and cnt_exact is unaffected.

Source files
------------

// File: rtl/approx_mul_share_ctrl.sv
// Round-robin scheduler sharing one 8x8 unsigned multiplier among NREQ requesters.
// Each operation is exact or two-term low-column-truncated approximate; issue and result stages.
module approx_mul_share_ctrl #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_x,
  input  logic [8*NREQ-1:0] req_y,
  input  logic [NREQ-1:0]   req_approx,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [15:0]       rsp_z,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_approx,
  output logic [15:0]       cnt_exact,
  output logic [15:0]       cnt_approx
);

  function automatic logic [15:0] mul_exact(input logic [7:0] x, input logic [7:0] y);
    return {8'd0, x} * {8'd0, y};
  endfunction

  // Drop the two low x columns and fold back only the two heaviest dropped partial-product bits.
  function automatic logic [15:0] mul_approx(input logic [7:0] x, input logic [7:0] y);
    logic [13:0] pp;
    logic [8:0]  c;
    pp = {6'd0, y} * {8'd0, x[7:2]};
    c  = {y[7] & x[1], (y[7] & x[0]) | (y[6] & x[1]), 7'd0};
    return {pp, 2'b00} + {7'd0, c};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic           found_s;
  logic [IDW-1:0] gnt_id_s;
  logic           s2_load_s;
  logic           s1_accept_s;
  logic           xfer_s;
  logic           rsp_xfer_s;
  logic [7:0]     x_sel_s;
  logic [7:0]     y_sel_s;
  logic           a_sel_s;
  logic [15:0]    prod_s;

  logic           s1_valid_q, s1_valid_d;
  logic [7:0]     s1_x_q, s1_x_d;
  logic [7:0]     s1_y_q, s1_y_d;
  logic           s1_approx_q, s1_approx_d;
  logic [IDW-1:0] s1_id_q, s1_id_d;

  logic           rsp_valid_q, rsp_valid_d;
  logic [15:0]    rsp_z_q, rsp_z_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic           rsp_approx_q, rsp_approx_d;
  logic [15:0]    cnt_exact_q, cnt_exact_d;
  logic [15:0]    cnt_approx_q, cnt_approx_d;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int   pos;
    logic hit;
    found_s  = 1'b0;
    gnt_id_s = '0;
    pos      = 0;
    hit      = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(rr_ptr_q) + k;
      pos = (pos >= NREQ) ? pos - NREQ : pos;
      for (int i = 0; i < NREQ; i++) begin
        hit      = !found_s && req_valid[i] && (i == pos);
        gnt_id_s = hit ? IDW'(i) : gnt_id_s;
        found_s  = found_s | hit;
      end
    end
  end

  assign s2_load_s   = !rsp_valid_q || rsp_ready;
  assign s1_accept_s = !s1_valid_q || s2_load_s;
  assign xfer_s      = found_s && s1_accept_s;
  assign rsp_xfer_s  = rsp_valid_q && rsp_ready;

  // Grant decode and operand select; operands only matter on a transfer cycle.
  always_comb begin
    req_ready = '0;
    x_sel_s   = 8'd0;
    y_sel_s   = 8'd0;
    a_sel_s   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = rst_n && xfer_s && (gnt_id_s == IDW'(i));
      x_sel_s      = (gnt_id_s == IDW'(i)) ? req_x[8*i +: 8] : x_sel_s;
      y_sel_s      = (gnt_id_s == IDW'(i)) ? req_y[8*i +: 8] : y_sel_s;
      a_sel_s      = (gnt_id_s == IDW'(i)) ? req_approx[i]   : a_sel_s;
    end
  end

  // Pointer advance and stage-1 next state.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    s1_valid_d  = s1_valid_q;
    s1_x_d      = s1_x_q;
    s1_y_d      = s1_y_q;
    s1_approx_d = s1_approx_q;
    s1_id_d     = s1_id_q;
    if (xfer_s) begin
      rr_ptr_d    = (gnt_id_s == IDW'(NREQ - 1)) ? '0 : gnt_id_s + IDW'(1);
      s1_valid_d  = 1'b1;
      s1_x_d      = x_sel_s;
      s1_y_d      = y_sel_s;
      s1_approx_d = a_sel_s;
      s1_id_d     = gnt_id_s;
    end else if (s2_load_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  assign prod_s = s1_approx_q ? mul_approx(s1_x_q, s1_y_q) : mul_exact(s1_x_q, s1_y_q);

  // Stage-2 result register and saturating delivery counters.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_z_d      = rsp_z_q;
    rsp_id_d     = rsp_id_q;
    rsp_approx_d = rsp_approx_q;
    if (s2_load_s) begin
      rsp_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        rsp_z_d      = prod_s;
        rsp_id_d     = s1_id_q;
        rsp_approx_d = s1_approx_q;
      end else begin
        rsp_z_d = rsp_z_q;
      end
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
    cnt_exact_d  = (rsp_xfer_s && !rsp_approx_q) ? sat_inc(cnt_exact_q)  : cnt_exact_q;
    cnt_approx_d = (rsp_xfer_s &&  rsp_approx_q) ? sat_inc(cnt_approx_q) : cnt_approx_q;
  end

  // State registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      s1_valid_q   <= 1'b0;
      s1_x_q       <= 8'd0;
      s1_y_q       <= 8'd0;
      s1_approx_q  <= 1'b0;
      s1_id_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_z_q      <= 16'd0;
      rsp_id_q     <= '0;
      rsp_approx_q <= 1'b0;
      cnt_exact_q  <= 16'd0;
      cnt_approx_q <= 16'd0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      s1_valid_q   <= s1_valid_d;
      s1_x_q       <= s1_x_d;
      s1_y_q       <= s1_y_d;
      s1_approx_q  <= s1_approx_d;
      s1_id_q      <= s1_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_z_q      <= rsp_z_d;
      rsp_id_q     <= rsp_id_d;
      rsp_approx_q <= rsp_approx_d;
      cnt_exact_q  <= cnt_exact_d;
      cnt_approx_q <= cnt_approx_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_z      = rsp_z_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_approx = rsp_approx_q;
  assign cnt_exact  = cnt_exact_q;
  assign cnt_approx = cnt_approx_q;

endmodule
